// File: rtl/frame_buffer_dbl.sv
// Double-buffered frame buffer: the rasterizer fills the back bank while the front bank streams to the DVI FIFO.
// Optional macro CLEAR_ON_SWAP_EN: after each bank swap, wipe the new back bank to BG_COLOR before accepting pixels.
module frame_buffer_dbl #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int COLOR_W = 3,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0,
    localparam int XW = $clog2(H_RES),
    localparam int YW = $clog2(V_RES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dvi_fifo_full,
    output logic [COLOR_W-1:0] dvi_color_out,
    output logic               dvi_fifo_write_enable,
    input  logic               rast_pixel_rdy,
    input  logic [COLOR_W-1:0] rast_color_input,
    input  logic [XW-1:0]      rast_width,
    input  logic [YW-1:0]      rast_height,
    input  logic               rast_done,
    output logic               read_rast_pixel_rdy,
    input  logic               next_frame_switch,
    output logic               front_bank
);
    localparam int DEPTH = H_RES * V_RES;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {CLEAR, SCAN, SWAP, WIPE} state_t;

    state_t             state;
    logic [COLOR_W-1:0] bank0 [DEPTH];
    logic [COLOR_W-1:0] bank1 [DEPTH];
    logic [XW-1:0]      scan_x;
    logic [YW-1:0]      scan_y;
    logic [AW-1:0]      fill_addr;
    logic               frame_req;
    logic               rast_fin;
    logic [COLOR_W-1:0] rd_data;

    logic               scanning;
    logic               rd_en;
    logic               last_px;
    logic               fill_active;
    logic               fill_last;
    logic               swap_now;
    logic               rast_in_range;
    logic [AW-1:0]      scan_addr;
    logic [AW-1:0]      rast_addr;

    assign scanning      = (state == SCAN) || (state == WIPE);
    assign rd_en         = scanning && !dvi_fifo_full;
    assign last_px       = (scan_x == XW'(H_RES - 1)) && (scan_y == YW'(V_RES - 1));
    assign swap_now      = rd_en && last_px && frame_req && rast_fin;
    assign fill_active   = (state == CLEAR) || (state == WIPE);
    assign fill_last     = (fill_addr == AW'(DEPTH - 1));
    assign scan_addr     = AW'(scan_y) * AW'(H_RES) + AW'(scan_x);
    assign rast_addr     = AW'(rast_height) * AW'(H_RES) + AW'(rast_width);
    assign rast_in_range = ({1'b0, rast_width} < (XW+1)'(H_RES)) &&
                           ({1'b0, rast_height} < (YW+1)'(V_RES));

    assign read_rast_pixel_rdy   = rast_pixel_rdy && (state == SCAN);
    assign dvi_color_out         = rd_data;

    // Fill writes both banks in CLEAR but only the back bank in WIPE; rasterizer writes always target the back bank.
    always_ff @(posedge clk) begin
        if (fill_active) begin
            if (state == CLEAR || front_bank)
                bank0[fill_addr] <= BG_COLOR;
            if (state == CLEAR || !front_bank)
                bank1[fill_addr] <= BG_COLOR;
        end else if (read_rast_pixel_rdy && rast_in_range) begin
            if (front_bank)
                bank0[rast_addr] <= rast_color_input;
            else
                bank1[rast_addr] <= rast_color_input;
        end
    end

    // Read data only updates on an issued read, so the DVI colour holds between strobes.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= front_bank ? bank1[scan_addr] : bank0[scan_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= CLEAR;
            front_bank            <= 1'b0;
            scan_x                <= '0;
            scan_y                <= '0;
            fill_addr             <= '0;
            frame_req             <= 1'b0;
            rast_fin              <= 1'b0;
            dvi_fifo_write_enable <= 1'b0;
        end else begin
            dvi_fifo_write_enable <= rd_en;
            // Pulses landing in the SWAP cycle belong to the next frame, so they survive the clear.
            frame_req <= (frame_req && state != SWAP) || next_frame_switch;
            rast_fin  <= (rast_fin && state != SWAP) || rast_done;

            if (fill_active)
                fill_addr <= fill_last ? '0 : fill_addr + 1'b1;

            if (rd_en) begin
                if (scan_x == XW'(H_RES - 1)) begin
                    scan_x <= '0;
                    scan_y <= (scan_y == YW'(V_RES - 1)) ? '0 : scan_y + 1'b1;
                end else begin
                    scan_x <= scan_x + 1'b1;
                end
            end

            case (state)
                CLEAR: if (fill_last) state <= SCAN;
                SCAN:  if (swap_now) state <= SWAP;
                SWAP: begin
                    front_bank <= ~front_bank;
                    fill_addr  <= '0;
`ifdef CLEAR_ON_SWAP_EN
                    state      <= WIPE;
`else
                    state      <= SCAN;
`endif
                end
                WIPE: begin
                    if (swap_now)
                        state <= SWAP;
                    else if (fill_last)
                        state <= SCAN;
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule
